dram_controller: RTL and testbench
==================================

# dram_controller

Fast-page-mode DRAM controller that responds to the active-low DRAM select from the system controller for the 0x000000–0xEFFFFF window. It multiplexes row and column addresses onto the DRAM address pins, generates RAS/CAS/WE, and returns the active-low DTACK_DRAM handshake. It also performs periodic CAS-before-RAS refresh, arbitrated against CPU accesses.

## Interface
- ROW_BITS, 11, row address width; must be ≥ COL_BITS.
- COL_BITS, 10, column address width.
- REFRESH_INTERVAL, 156, CLK cycles between refresh requests (15.6 µs at 10 MHz).
- RAS_PRECHARGE, 2, minimum cycles spent in PRE; must be ≥ 1.

Ports:
- CLK  in  1  controller clock, same clock as CLK_CPU.
- RST  in  1  reset; asynchronous, active-low.
- DRAM  in  1  active-low select from the system controller.
- AS, UDS, LDS, RW  in  1 each  68000 bus strobes (AS/UDS/LDS active-low); RW is 1 for read.
- ADDR  in  ROW_BITS+COL_BITS  CPU word address A[ROW_BITS+COL_BITS:1]; row = upper ROW_BITS, col = lower COL_BITS.
- MA  out  ROW_BITS  multiplexed DRAM address; column is zero-extended.
- RAS  out  1  active-low row strobe.
- CASU, CASL  out  1 each  active-low column strobes, upper and lower byte.
- WE  out  1  active-low write enable.
- DTACK_DRAM  out  1  active-low acknowledge to the system controller.

## Operation
- All outputs are registered. Reset values: RAS=CASU=CASL=WE=DTACK_DRAM=1, MA=0. Reset also forces state IDLE, refresh counter 0, and pending flag 0. Reset asserted mid-cycle takes effect immediately.
- States: IDLE, ROW, COL, CAS, HOLD, PRE, REF1, REF2, REF3.
- Refresh counter:
  - Free-runs from 0 to REFRESH_INTERVAL-1, then wraps and sets `pending`.
  - If `pending` is already set at wrap, it stays set; only one refresh is queued.
- IDLE:
  - If `pending`=1: go to REF1 and clear `pending`. Refresh wins over a simultaneous access.
  - Else if DRAM=0 and AS=0: load MA with the row and go to ROW.
  - DRAM=0 with AS=1 is ignored.
- ROW: RAS←0; go to COL.
- COL: MA←col; WE←RW (low for writes); go to CAS.
- CAS: CASU←UDS; CASL←LDS; DTACK_DRAM←0; go to HOLD.
- HOLD: hold all strobes until AS is sampled high. Then RAS, CASU, CASL, WE, and DTACK_DRAM go to 1 on the same edge; go to PRE.
- Abort: AS sampled high in ROW, COL, or CAS releases all strobes and goes to PRE. DTACK_DRAM is never asserted in this case.
- PRE: stay RAS_PRECHARGE cycles, then go to IDLE.
- Refresh sequence:
  - REF1: CASU=CASL=0.
  - REF2: RAS←0.
  - REF3: hold.
  - Then release RAS and CAS together and go to PRE.
  - WE and DTACK_DRAM stay 1 throughout.

## Timing
- Access latency: DTACK_DRAM falls on the 4th rising edge after the edge that samples DRAM=0, AS=0 in IDLE. Edge 1 loads the row onto MA, edge 2 drops RAS, edge 3 loads the column, edge 4 drops CAS and DTACK_DRAM.
- MA is stable at least 1 cycle before each RAS or CAS falling edge.
- CAS-before-RAS lead during refresh is 1 cycle; RAS is low for 2 cycles.
- Release: 1 cycle after AS rises (sampled edge).
- RAS stays high for at least RAS_PRECHARGE+1 cycles between activations.
- Worst case with a refresh collision: DTACK_DRAM falls on edge 4+3+RAS_PRECHARGE+… = edge 10 with default parameters.

## Configuration
- DRAM_EARLY_DTACK_EN:
  - Defined: DTACK_DRAM←0 on the COL edge (edge 3), one cycle before CAS. Access latency is 3 edges, for fast DRAM where the 68000 data-sampling state covers tCAC.
  - Undefined: DTACK_DRAM asserts with CAS on edge 4.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: hold RST=0 mid-access → RAS=CASU=CASL=WE=DTACK_DRAM=1 and MA=0 immediately. After release, the first refresh occurs 156 cycles later.
- Word read at byte address 0x123456 (word 0x91A2B), RW=1, UDS=LDS=0 → MA=0x246 at edge 1, RAS low at edge 2, MA=0x22B at edge 3, CASU/CASL/DTACK_DRAM low at edge 4. All strobes high 1 edge after AS rises.
- Lower-byte write, RW=0, LDS=0, UDS=1 → WE=0 from edge 3, CASL=0 and CASU=1 at edge 4.
- Idle for 156 cycles → CASU=CASL=0 for 1 cycle, then RAS=0 for 2 cycles with DTACK_DRAM=1 throughout. No second refresh until the next wrap.
- Request in the same cycle `pending` is set → refresh runs first; DTACK_DRAM falls at edge 10 (edge 9 with DRAM_EARLY_DTACK_EN).
- AS deasserted while in COL → no CAS and no DTACK_DRAM; RAS high next edge; controller returns to IDLE after PRE.

Source files
------------

// File: rtl/dram_controller.sv
// rtl/dram_controller.sv - fast-page-mode DRAM controller with CAS-before-RAS refresh
// Optional build macro DRAM_EARLY_DTACK_EN asserts DTACK_DRAM on the column edge.
`timescale 1ns/1ps
module dram_controller #(
   parameter int ROW_BITS         = 11,
   parameter int COL_BITS         = 10,
   parameter int REFRESH_INTERVAL = 156,
   parameter int RAS_PRECHARGE    = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         DRAM,
   input  logic                         AS,
   input  logic                         UDS,
   input  logic                         LDS,
   input  logic                         RW,
   input  logic [ROW_BITS+COL_BITS-1:0] ADDR,
   output logic [ROW_BITS-1:0]          MA,
   output logic                         RAS,
   output logic                         CASU,
   output logic                         CASL,
   output logic                         WE,
   output logic                         DTACK_DRAM
);
   localparam int REF_W = $clog2(REFRESH_INTERVAL + 1);
   localparam int PRE_W = $clog2(RAS_PRECHARGE + 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_INTERVAL - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAS_PRECHARGE - 1);

   typedef enum logic [3:0] {IDLE, ROW, COL, CAS, HOLD, PRE, REF1, REF2, REF3} state_t;

   state_t              state, state_nx;
   logic [REF_W-1:0]    ref_cnt;
   logic [PRE_W-1:0]    pre_cnt, pre_cnt_nx;
   logic                pending, pending_nx, wrap;
   logic [ROW_BITS-1:0] ma_nx, row_addr, col_addr;
   logic                ras_nx, casu_nx, casl_nx, we_nx, dtack_nx;

   assign row_addr = ADDR[ROW_BITS+COL_BITS-1:COL_BITS];
   assign col_addr = ROW_BITS'(ADDR[COL_BITS-1:0]);
   assign wrap     = (ref_cnt == REF_LAST);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ref_cnt <= '0;
      end else if (wrap) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      pre_cnt_nx = '0;
      pending_nx = pending | wrap;
      ma_nx      = MA;
      ras_nx     = RAS;
      casu_nx    = CASU;
      casl_nx    = CASL;
      we_nx      = WE;
      dtack_nx   = DTACK_DRAM;
      unique case (state)
         IDLE: begin
            // A queued refresh beats a CPU request seen on the same edge;
            // a wrap on this very edge re-queues the next one.
            if (pending) begin
               casu_nx    = 1'b0;
               casl_nx    = 1'b0;
               pending_nx = wrap;
               state_nx   = REF1;
            end else if (!DRAM && !AS) begin
               ma_nx    = row_addr;
               state_nx = ROW;
            end
         end
         ROW, COL, CAS, HOLD: begin
            if (AS) begin
               ras_nx   = 1'b1;
               casu_nx  = 1'b1;
               casl_nx  = 1'b1;
               we_nx    = 1'b1;
               dtack_nx = 1'b1;
               state_nx = PRE;
            end else if (state == ROW) begin
               ras_nx   = 1'b0;
               state_nx = COL;
            end else if (state == COL) begin
               ma_nx    = col_addr;
               we_nx    = RW;
`ifdef DRAM_EARLY_DTACK_EN
               dtack_nx = 1'b0;
`endif
               state_nx = CAS;
            end else if (state == CAS) begin
               casu_nx  = UDS;
               casl_nx  = LDS;
               dtack_nx = 1'b0;
               state_nx = HOLD;
            end
         end
         PRE: begin
            if (pre_cnt == PRE_LAST) begin
               state_nx = IDLE;
            end else begin
               pre_cnt_nx = pre_cnt + 1'b1;
            end
         end
         REF1: begin
            ras_nx   = 1'b0;
            state_nx = REF2;
         end
         REF2: state_nx = REF3;
         REF3: begin
            ras_nx   = 1'b1;
            casu_nx  = 1'b1;
            casl_nx  = 1'b1;
            state_nx = PRE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         pre_cnt    <= '0;
         pending    <= 1'b0;
         MA         <= '0;
         RAS        <= 1'b1;
         CASU       <= 1'b1;
         CASL       <= 1'b1;
         WE         <= 1'b1;
         DTACK_DRAM <= 1'b1;
      end else begin
         state      <= state_nx;
         pre_cnt    <= pre_cnt_nx;
         pending    <= pending_nx;
         MA         <= ma_nx;
         RAS        <= ras_nx;
         CASU       <= casu_nx;
         CASL       <= casl_nx;
         WE         <= we_nx;
         DTACK_DRAM <= dtack_nx;
      end
   end
endmodule

// File: tb/tb_dram_controller.sv
// tb/tb_dram_controller.sv - self-checking bench for dram_controller
// Expected outputs come from an edge-number schedule of accesses and refreshes.
`timescale 1ns/1ps
module tb_dram_controller;
   localparam int ROW_BITS         = 11;
   localparam int COL_BITS         = 10;
   localparam int REFRESH_INTERVAL = 156;
   localparam int RAS_PRECHARGE    = 2;
   localparam int AW               = ROW_BITS + COL_BITS;
`ifdef DRAM_EARLY_DTACK_EN
   localparam int DT_OFS = 2;
`else
   localparam int DT_OFS = 3;
`endif

   logic                CLK = 1'b0;
   logic                RST = 1'b0;
   logic                DRAM = 1'b1, AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
   logic [AW-1:0]       ADDR = '0;
   logic [ROW_BITS-1:0] MA;
   logic                RAS, CASU, CASL, WE, DTACK_DRAM;

   dram_controller #(
      .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
      .REFRESH_INTERVAL(REFRESH_INTERVAL), .RAS_PRECHARGE(RAS_PRECHARGE)
   ) dut (
      .CLK(CLK), .RST(RST), .DRAM(DRAM), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
      .ADDR(ADDR), .MA(MA), .RAS(RAS), .CASU(CASU), .CASL(CASL), .WE(WE),
      .DTACK_DRAM(DTACK_DRAM)
   );

   always #50 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   // Schedule: n counts rising edges since reset release.
   int                  n, idle_at, v_ref, rr, a_t, a_h, a_hold;
   bit                  acc_active, req_on;
   logic                a_rw, a_uds, a_lds;
   logic [AW-1:0]       a_addr;
   logic [ROW_BITS-1:0] ma_exp, ma_at_row, ma_at_col;
   logic                dt_prev, casu_prev;
   int                  dtack_fall, dtack_falls, cbr_edge;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n = 0; idle_at = 1; v_ref = REFRESH_INTERVAL + 1;
      rr = -100; a_t = -100; a_h = -100;
      acc_active = 0; req_on = 0; ma_exp = '0;
      dt_prev = 1'b1; casu_prev = 1'b1; cbr_edge = -1;
   endtask

   task automatic model_edge();
      if (acc_active && n == a_h) begin
         acc_active = 0;
         idle_at = a_h + 1 + RAS_PRECHARGE;
      end
      if (!acc_active && n >= idle_at) begin
         if (v_ref <= n) begin
            rr = n;
            idle_at = n + 4 + RAS_PRECHARGE;
            v_ref = REFRESH_INTERVAL * ((n - 1) / REFRESH_INTERVAL + 1) + 1;
         end else if (req_on) begin
            acc_active = 1; a_t = n; a_h = n + a_hold;
         end
      end
      if (acc_active && n == a_t)     ma_exp = a_addr[AW-1:COL_BITS];
      if (acc_active && n == a_t + 2) ma_exp = ROW_BITS'(a_addr[COL_BITS-1:0]);
   endtask

   function automatic logic [ROW_BITS+4:0] expect_out(input int e);
      logic ras, casu, casl, we, dt;
      ras = 1'b1; casu = 1'b1; casl = 1'b1; we = 1'b1; dt = 1'b1;
      if (e >= rr && e <= rr + 2)     begin casu = 1'b0; casl = 1'b0; end
      if (e >= rr + 1 && e <= rr + 2) ras = 1'b0;
      if (e >= a_t + 1 && e < a_h)    ras = 1'b0;
      if (e >= a_t + 2 && e < a_h)    we = a_rw;
      if (e >= a_t + 3 && e < a_h)    begin casu = a_uds; casl = a_lds; end
      if (e >= a_t + DT_OFS && e < a_h) dt = 1'b0;
      return {ma_exp, ras, casu, casl, we, dt};
   endfunction

   task automatic step();
      @(posedge CLK); #1;
      n++;
      model_edge();
      chk($sformatf("cycle %0d outputs", n),
          32'({MA, RAS, CASU, CASL, WE, DTACK_DRAM}), 32'(expect_out(n)));
      if (n == a_t)     ma_at_row = MA;
      if (n == a_t + 2) ma_at_col = MA;
      if (!DTACK_DRAM && dt_prev) begin dtack_fall = n; dtack_falls++; end
      if (!CASU && casu_prev && RAS) cbr_edge = n;
      dt_prev = DTACK_DRAM; casu_prev = CASU;
      if (acc_active && n == a_h - 1) begin AS = 1'b1; DRAM = 1'b1; req_on = 0; end
   endtask

   task automatic issue(input logic [AW-1:0] addr, input logic rw, input logic uds,
                        input logic lds, input int hold);
      ADDR = addr; RW = rw; UDS = uds; LDS = lds;
      a_addr = addr; a_rw = rw; a_uds = uds; a_lds = lds; a_hold = hold;
      DRAM = 1'b0; AS = 1'b0; req_on = 1;
   endtask

   task automatic run_until_idle();
      for (int g = 0; g < 200 && (req_on || acc_active); g++) step();
      chk("access completes", 32'(req_on || acc_active), 32'd0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int   v_coll, falls_before, gap, sel, hold;
   logic rw_r;

   initial begin
      dtack_falls = 0; dtack_fall = -1;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("reset outputs", 32'({MA, RAS, CASU, CASL, WE, DTACK_DRAM}), 32'({11'h000, 5'b11111}));
      RST = 1'b1;
      model_reset();

      // Word read at byte 0x123456
      issue(21'h091A2B, 1'b1, 1'b0, 1'b0, 6);
      run_until_idle();
      chk("read row on MA", 32'(ma_at_row), 32'h246);
      chk("read col on MA", 32'(ma_at_col), 32'h22B);
      chk("read dtack latency", 32'(dtack_fall - a_t), 32'(DT_OFS));

      // Lower-byte write
      issue(AW'($urandom), 1'b0, 1'b1, 1'b0, 5);
      run_until_idle();
      chk("write dtack latency", 32'(dtack_fall - a_t), 32'(DT_OFS));

      // Idle through the first refresh
      while (n < REFRESH_INTERVAL + 11) step();
      chk("first refresh edge", 32'(cbr_edge), 32'(REFRESH_INTERVAL + 1));

      // Request first sampled on the edge where pending becomes visible
      while (n < v_ref - 1) step();
      v_coll = v_ref;
      issue(AW'($urandom), 1'b1, 1'b0, 1'b0, 5);
      run_until_idle();
      chk("collision dtack edge", 32'(dtack_fall - v_coll + 1), 32'(DT_OFS + 7));
      chk("collision refresh first", 32'(rr), 32'(v_coll));

      // Abort while in COL
      falls_before = dtack_falls;
      issue(AW'($urandom), 1'b1, 1'b0, 1'b0, 2);
      run_until_idle();
      chk("abort no dtack", 32'(dtack_falls), 32'(falls_before));

      // Randomized traffic, with ignored DRAM-only selects during gaps
      for (int k = 0; k < 40; k++) begin
         gap = $urandom_range(0, 30);
         for (int g = 0; g < gap; g++) begin
            DRAM = 1'($urandom_range(0, 1)); AS = 1'b1;
            step();
         end
         DRAM = 1'b1;
         sel  = $urandom_range(0, 2);
         hold = $urandom_range(1, 7);
         rw_r = 1'($urandom_range(0, 1));
         issue(AW'($urandom), rw_r, 1'(sel == 1), 1'(sel == 2), hold);
         run_until_idle();
      end

      // Reset in the middle of an access
      issue(AW'($urandom), 1'b0, 1'b0, 1'b0, 7);
      for (int g = 0; g < 200 && !(acc_active && n == a_t + 3); g++) step();
      chk("mid-access reached", 32'(acc_active && n == a_t + 3), 32'd1);
      #10 RST = 1'b0;
      #1;
      chk("async reset outputs", 32'({MA, RAS, CASU, CASL, WE, DTACK_DRAM}), 32'({11'h000, 5'b11111}));
      DRAM = 1'b1; AS = 1'b1;
      @(posedge CLK); #1;
      chk("held reset outputs", 32'({MA, RAS, CASU, CASL, WE, DTACK_DRAM}), 32'({11'h000, 5'b11111}));
      RST = 1'b1;
      model_reset();
      repeat (REFRESH_INTERVAL + 4) step();
      chk("refresh after reset", 32'(cbr_edge), 32'(REFRESH_INTERVAL + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
